// File: rtl/csa_acc_pkg.sv
// Shared types and helpers for the carry-save accumulator.
package csa_acc_pkg;

  typedef enum logic {
    ACCUM   = 1'b0,
    RESOLVE = 1'b1
  } state_e;

  function automatic int nchunk(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

  // One column of a 3:2 compressor: returns {carry, sum}.
  function automatic logic [1:0] compress3_2(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

endpackage

// File: rtl/csa_accumulator_compress.sv
// Combinational vector 3:2 compressor: sum_o + 2*carry_o == a_i + b_i + c_i.
module csa_compress
  import csa_acc_pkg::*;
#(
  parameter int WIDTH = 3134
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  output logic [WIDTH-1:0] sum_o,
  output logic [WIDTH-1:0] carry_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign {carry_o[i], sum_o[i]} = compress3_2(a_i[i], b_i[i], c_i[i]);
  end

endmodule

// File: rtl/csa_accumulator.sv
// Carry-save multi-operand accumulator with chunked carry-propagate resolve.
// Define CSA_ACC_OVF_EN to add the sticky ovf output for discarded carries.
module csa_accumulator
  import csa_acc_pkg::*;
#(
  parameter int WIDTH = 3134,
  parameter int CHUNK = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             res_start,
  output logic             busy,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data
`ifdef CSA_ACC_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int LASTW  = WIDTH - (NCHUNK - 1) * CHUNK;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic [WIDTH-1:0]  c_q, c_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [KW-1:0]     k_q, k_d;
  logic              cb_q, cb_d;
  logic              rv_q, rv_d;

  logic [WIDTH-1:0]  c_sh;
  logic [WIDTH-1:0]  cmp_s, cmp_c;
  logic              fire;
  logic [31:0]       base;
  logic [CHUNK-1:0]  chunk_a, chunk_b;
  logic [CHUNK:0]    chunk_sum;
  logic [WIDTH-1:0]  chunk_mask;
  logic [WIDTH-1:0]  s_merged;

  // Carry bit i has weight 2^(i+1); the top bit falls off (mod 2^WIDTH).
  assign c_sh = c_q << 1;

  csa_compress #(
    .WIDTH(WIDTH)
  ) u_compress (
    .a_i    (s_q),
    .b_i    (c_sh),
    .c_i    (in_data),
    .sum_o  (cmp_s),
    .carry_o(cmp_c)
  );

  assign in_ready  = (state_q == ACCUM);
  assign busy      = (state_q == RESOLVE);
  assign fire      = in_valid && in_ready;
  assign res_valid = rv_q;
  assign res_data  = res_q;

  // Shifts zero-fill past WIDTH, so the short last chunk needs no special case.
  assign base       = 32'(k_q) * 32'(CHUNK);
  assign chunk_a    = CHUNK'(s_q >> base);
  assign chunk_b    = CHUNK'(c_sh >> base);
  assign chunk_sum  = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, cb_q};
  assign chunk_mask = WIDTH'({CHUNK{1'b1}}) << base;

  // Resolved chunks overwrite s_q in place; later chunks only read higher bits.
  assign s_merged = (s_q & ~chunk_mask) | (WIDTH'(chunk_sum[CHUNK-1:0]) << base);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    res_d   = res_q;
    k_d     = k_q;
    cb_d    = cb_q;
    rv_d    = 1'b0;
    if (clr) begin
      state_d = ACCUM;
      s_d     = '0;
      c_d     = '0;
      res_d   = '0;
      k_d     = '0;
      cb_d    = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (fire) begin
            s_d = cmp_s;
            c_d = cmp_c;
          end
          if (res_start) begin
            state_d = RESOLVE;
            k_d     = '0;
            cb_d    = 1'b0;
          end
        end
        RESOLVE: begin
          s_d  = s_merged;
          cb_d = chunk_sum[CHUNK];
          k_d  = k_q + KW'(1);
          if (k_q == K_LAST) begin
            c_d     = '0;
            res_d   = s_merged;
            rv_d    = 1'b1;
            state_d = ACCUM;
            k_d     = '0;
            cb_d    = 1'b0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      s_q     <= '0;
      c_q     <= '0;
      res_q   <= '0;
      k_q     <= '0;
      cb_q    <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      res_q   <= res_d;
      k_q     <= k_d;
      cb_q    <= cb_d;
      rv_q    <= rv_d;
    end
  end

`ifdef CSA_ACC_OVF_EN
  logic ovf_q, ovf_d;

  // The carry out of the final chunk sits at bit LASTW of the chunk sum.
  always_comb begin
    ovf_d = ovf_q;
    if (clr) begin
      ovf_d = 1'b0;
    end else if (state_q == ACCUM && fire && c_q[WIDTH-1]) begin
      ovf_d = 1'b1;
    end else if (state_q == RESOLVE && k_q == K_LAST && chunk_sum[LASTW]) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed scoreboard bench for csa_accumulator (16-bit and 18-bit instances, CHUNK=4).
module tb_csa_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        clr16, v16, rs16, rdy16, busy16, rv16;
  logic [15:0] d16, rd16;
  logic        clr18, v18, rs18, rdy18, busy18, rv18;
  logic [17:0] d18, rd18;
`ifdef CSA_ACC_OVF_EN
  logic        ovf16, ovf18;
`endif

  csa_accumulator #(.WIDTH(16), .CHUNK(4)) u_dut16 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr16),
    .in_valid (v16),
    .in_ready (rdy16),
    .in_data  (d16),
    .res_start(rs16),
    .busy     (busy16),
    .res_valid(rv16),
    .res_data (rd16)
`ifdef CSA_ACC_OVF_EN
    ,
    .ovf      (ovf16)
`endif
  );

  csa_accumulator #(.WIDTH(18), .CHUNK(4)) u_dut18 (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr18),
    .in_valid (v18),
    .in_ready (rdy18),
    .in_data  (d18),
    .res_start(rs18),
    .busy     (busy18),
    .res_valid(rv18),
    .res_data (rd18)
`ifdef CSA_ACC_OVF_EN
    ,
    .ovf      (ovf18)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] q16[$];
  logic [17:0] q18[$];
  logic [15:0] e16;
  logic [17:0] e18;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: every res_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rv16 === 1'b1) begin
      if (q16.size() == 0) chk("res16_unexpected", 32'(rv16), 32'h0);
      else begin
        e16 = q16.pop_front();
        chk("res16_data", 32'(rd16), 32'(e16));
      end
    end
    if (rst_n === 1'b1 && rv18 === 1'b1) begin
      if (q18.size() == 0) chk("res18_unexpected", 32'(rv18), 32'h0);
      else begin
        e18 = q18.pop_front();
        chk("res18_data", 32'(rd18), 32'(e18));
      end
    end
  end

  task automatic send16(input logic [15:0] d);
    v16 = 1'b1;
    d16 = d;
    for (int n = 0; n < 50 && rdy16 !== 1'b1; n++) tick();
    chk("send16_ready", 32'(rdy16), 32'h1);
    tick();
    v16 = 1'b0;
  endtask

  task automatic send18(input logic [17:0] d);
    v18 = 1'b1;
    d18 = d;
    for (int n = 0; n < 50 && rdy18 !== 1'b1; n++) tick();
    chk("send18_ready", 32'(rdy18), 32'h1);
    tick();
    v18 = 1'b0;
  endtask

  task automatic wait_res16(input int lat, input string tag);
    int n;
    n = 0;
    while (rv16 !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk(tag, 32'(n), 32'(lat));
    tick();
    chk({tag, "_pulse"}, 32'(rv16), 32'h0);
  endtask

  task automatic wait_res18(input int lat, input string tag);
    int n;
    n = 0;
    while (rv18 !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk(tag, 32'(n), 32'(lat));
    tick();
    chk({tag, "_pulse"}, 32'(rv18), 32'h0);
  endtask

  task automatic resolve16(input logic [15:0] exp, input string tag);
    rs16 = 1'b1;
    q16.push_back(exp);
    tick();
    rs16 = 1'b0;
    wait_res16(4, tag);
  endtask

  task automatic resolve18(input logic [17:0] exp, input string tag);
    rs18 = 1'b1;
    q18.push_back(exp);
    tick();
    rs18 = 1'b0;
    wait_res18(5, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    {clr16, v16, rs16, clr18, v18, rs18} = '0;
    d16 = '0;
    d18 = '0;
    #1 rst_n = 1'b0;
    #3;
    chk("rst_ready16", 32'(rdy16), 32'h1);
    chk("rst_busy16",  32'(busy16), 32'h0);
    chk("rst_valid16", 32'(rv16), 32'h0);
    chk("rst_data16",  32'(rd16), 32'h0);
    chk("rst_ready18", 32'(rdy18), 32'h1);
    chk("rst_data18",  32'(rd18), 32'h0);
`ifdef CSA_ACC_OVF_EN
    chk("rst_ovf16", 32'(ovf16), 32'h0);
`endif
    #8 rst_n = 1'b1;
    tick();

    // Basic sum and resolve latency
    send16(16'h1234);
    send16(16'h0FFF);
    send16(16'h0001);
    resolve16(16'h2234, "t1_latency");
    chk("t1_hold", 32'(rd16), 32'h2234);
`ifdef CSA_ACC_OVF_EN
    chk("t1_ovf", 32'(ovf16), 32'h0);
`endif

    // Wrap-around modulo 2^16
    clr16 = 1'b1;
    tick();
    clr16 = 1'b0;
    chk("t2_clr_data", 32'(rd16), 32'h0);
    send16(16'hFFFF);
    send16(16'h0002);
    resolve16(16'h0001, "t2_latency");
`ifdef CSA_ACC_OVF_EN
    chk("t2_ovf_set", 32'(ovf16), 32'h1);
    tick();
    tick();
    chk("t2_ovf_sticky", 32'(ovf16), 32'h1);
`endif
    clr16 = 1'b1;
    tick();
    clr16 = 1'b0;
`ifdef CSA_ACC_OVF_EN
    chk("t2_ovf_clr", 32'(ovf16), 32'h0);
`endif

    // 18-bit width with a partial last chunk
    send18(18'h3FFFF);
    send18(18'h00001);
    resolve18(18'h00000, "t3_latency1");
`ifdef CSA_ACC_OVF_EN
    chk("t3_ovf", 32'(ovf18), 32'h1);
`endif
    send18(18'h12345);
    resolve18(18'h12345, "t3_latency2");

    // Operand held across a resolve is absorbed exactly once afterwards
    rs16 = 1'b1;
    q16.push_back(16'h0000);
    tick();
    rs16 = 1'b0;
    v16 = 1'b1;
    d16 = 16'h0010;
    for (int i = 0; i < 4; i++) begin
      chk("t4_busy", 32'(busy16), 32'h1);
      chk("t4_ready", 32'(rdy16), 32'h0);
      tick();
    end
    chk("t4_busy_end", 32'(busy16), 32'h0);
    chk("t4_ready_end", 32'(rdy16), 32'h1);
    chk("t4_valid", 32'(rv16), 32'h1);
    tick();
    v16 = 1'b0;
    resolve16(16'h0010, "t4_latency");

    // clr in the second resolve cycle aborts it
    rs16 = 1'b1;
    tick();
    rs16 = 1'b0;
    tick();
    clr16 = 1'b1;
    tick();
    clr16 = 1'b0;
    chk("t5_data", 32'(rd16), 32'h0);
    chk("t5_busy", 32'(busy16), 32'h0);
    for (int i = 0; i < 5; i++) begin
      chk("t5_no_valid", 32'(rv16), 32'h0);
      tick();
    end
    send16(16'h0005);
    resolve16(16'h0005, "t5_latency");

    // Asynchronous reset mid-resolve
    rs16 = 1'b1;
    tick();
    rs16 = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_data", 32'(rd16), 32'h0);
    chk("t6_busy", 32'(busy16), 32'h0);
    chk("t6_ready", 32'(rdy16), 32'h1);
    chk("t6_valid", 32'(rv16), 32'h0);
    #3 rst_n = 1'b1;
    tick();
    v16  = 1'b1;
    d16  = 16'h0007;
    rs16 = 1'b1;
    q16.push_back(16'h0007);
    tick();
    v16  = 1'b0;
    rs16 = 1'b0;
    wait_res16(4, "t6_latency");

    tick();
    chk("q16_drained", 32'(q16.size()), 32'h0);
    chk("q18_drained", 32'(q18.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csa_accumulator.md
Name: csa_accumulator

Overview:
- Multi-operand accumulator for wide big-integer datapaths (Montgomery/RSA, default 3072+54+8 bits).
- Keeps its running total in redundant carry-save form (sum vector + carry vector), so each accepted operand costs one 3:2 compression per cycle with no carry chain.
- On request, resolves the redundant pair to binary with a chunked carry-propagate adder, CHUNK bits per cycle.
- Replaces ad-hoc carry-save trees wherever a stream of partial products must be summed.

Parameters:
- WIDTH, 3134, operand/accumulator width in bits; all arithmetic is modulo 2^WIDTH.
- CHUNK, 64, bits resolved per cycle in the final carry-propagate phase; 1 <= CHUNK <= WIDTH.
- NCHUNK (localparam), ceil(WIDTH/CHUNK), number of resolve cycles.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear of accumulator; aborts a resolve
- in_valid  in  1  operand valid
- in_ready  out  1  operand accepted when in_valid && in_ready
- in_data  in  WIDTH  operand
- res_start  in  1  request resolve; honoured only in ACCUM
- busy  out  1  high in RESOLVE
- res_valid  out  1  one-cycle pulse: res_data holds the new binary total
- res_data  out  WIDTH  resolved total; held until the next resolve completes, clr, or reset

Behaviour:
- Registers: s_reg[WIDTH], c_reg[WIDTH] (c_reg[i] = carry with weight 2^(i+1)), res_reg, chunk index k, carry bit cb, state.
- Reset (async, rst_n=0): s_reg=c_reg=res_data=0; res_valid=0; busy=0; state=ACCUM. in_ready is combinational and therefore 1 immediately.
- States:
  - ACCUM: in_ready=1.
  - RESOLVE: in_ready=0, busy=1.
- Accumulate (ACCUM, handshake fires):
  - c_sh = {c_reg[WIDTH-2:0],1'b0}.
  - Per bit: s_reg <= s_reg ^ c_sh ^ in_data; c_reg <= maj(s_reg, c_sh, in_data).
  - c_reg[WIDTH-1] is carried but discarded on the next shift (mod 2^WIDTH).
- res_start in ACCUM -> RESOLVE, with k=0, cb=0.
  - If a handshake fires in the same cycle, that operand is compressed first and the resolve uses the updated registers.
- RESOLVE, each cycle for chunk k:
  - {cb, res_reg[k*CHUNK +: CHUNK]} <= s_reg chunk + c_sh chunk + cb.
  - The last chunk is truncated to WIDTH-(NCHUNK-1)*CHUNK bits; its carry-out is dropped.
  - On k=NCHUNK-1:
    - res_valid=1 next cycle and res_data updated.
    - s_reg <= resolved value, c_reg <= 0.
    - state -> ACCUM, so accumulation continues from the binary total.
- Latency: res_start high in cycle N -> res_valid high in cycle N+NCHUNK+1. Throughput: 1 operand/cycle in ACCUM.
- res_start in RESOLVE: ignored.
- in_valid in RESOLVE: not accepted; the operand must be held by the source.
- clr (any state, priority over handshake/res_start):
  - Next cycle: s_reg=c_reg=0, res_data=0, state=ACCUM, no res_valid.
  - An operand presented that cycle is dropped.
- Reset mid-resolve: as reset; no res_valid.

Optional Feature:
- CSA_ACC_OVF_EN defined: adds output ovf (1 bit, reset 0), a sticky flag.
  - Sets when a nonzero carry is discarded: c_reg[WIDTH-1] shifted out on accumulate, or carry-out of the final resolve chunk.
  - Cleared by clr or reset.
  - Note: a carry-save overflow can cancel later; ovf reports any discard.
- Not defined: no ovf port, no extra logic; wrap-around is silent.

Decomposition:
- Package csa_acc_pkg:
  - state enum {ACCUM, RESOLVE};
  - function nchunk(WIDTH, CHUNK);
  - 3:2 compress function for a vector.
- One natural sub-module: csa_compress (parametrised WIDTH, combinational vector 3:2 compressor). It is reused by the accumulate path.

Test Plan:
1. WIDTH=16, CHUNK=4: accept 0x1234, 0x0FFF, 0x0001, res_start -> res_data=0x2234; res_valid exactly 5 cycles after res_start; one-cycle pulse.
2. WIDTH=16: accumulate 0xFFFF, 0x0002, resolve -> res_data=0x0001; with CSA_ACC_OVF_EN, ovf=1 and stays 1 until clr.
3. WIDTH=18, CHUNK=4 (NCHUNK=5, partial last chunk): accumulate 0x3FFFF, 0x00001, then 0x12345 after the resolve -> first res_data=0x00000, second=0x12345.
4. Hold in_valid=1 with 0x0010 across a resolve -> in_ready=0 and busy=1 for 4 cycles; operand absorbed once afterwards; the next resolve adds exactly 0x0010.
5. Assert clr at the 2nd RESOLVE cycle -> no res_valid, res_data=0; next accumulate of 0x0005 then resolve gives 0x0005.
6. Drop rst_n mid-resolve (asynchronously, between edges) -> outputs zero immediately, state ACCUM; after release, in_valid+res_start in the same cycle with 0x0007 -> res_data=0x0007.
